block_formation: RTL

BLOCK_FORMATION -- requirements
Module: block_formation

---
 rtl/block_formation.sv | 101 ++++++++++
 1 files changed

// File: rtl/block_formation.sv
// Groups raster-ordered HOG cell histograms into 2x2 blocks using a one-row line
// buffer plus left-neighbour registers; outputs are registered one cycle after each cell.
module block_formation #(
  parameter int BIN_WIDTH     = 14,
  parameter int BINS          = 9,
  parameter int CELLS_PER_ROW = 80,
  parameter int CELL_ROWS     = 60,
  parameter int CELL_WIDTH    = BIN_WIDTH*(BINS+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [CELL_WIDTH-1:0]   cell_hist,
  output logic                    out_valid,
  output logic                    k_border,
  output logic [4*CELL_WIDTH-1:0] block_histograms,
  output logic                    frame_done
);

  localparam int COL_W = (CELLS_PER_ROW > 1) ? $clog2(CELLS_PER_ROW) : 1;
  localparam int ROW_W = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELLS_PER_ROW-1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELL_ROWS-1);

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [CELL_WIDTH-1:0] line_buf [CELLS_PER_ROW];
  logic [CELL_WIDTH-1:0] prev_top;
  logic [CELL_WIDTH-1:0] prev_bottom;

  logic [COL_W-1:0]      cur_col_p0;
  logic [ROW_W-1:0]      cur_row_p0;
  logic [COL_W-1:0]      nxt_col_p0;
  logic [ROW_W-1:0]      nxt_row_p0;
  logic [CELL_WIDTH-1:0] top_p0;
  logic                  emit_p0;
  logic                  last_p0;

  logic                    vld_p1;
  logic                    kb_p1;
  logic                    fd_p1;
  logic [4*CELL_WIDTH-1:0] blk_p1;

  // Stage p0: position of the incoming cell (sof forces the frame origin)
  always_comb begin
    cur_col_p0 = in_sof ? '0 : col;
    cur_row_p0 = in_sof ? '0 : row;
    nxt_col_p0 = cur_col_p0 + COL_W'(1);
    nxt_row_p0 = cur_row_p0;
    if (cur_col_p0 == COL_LAST) begin
      nxt_col_p0 = '0;
      nxt_row_p0 = (cur_row_p0 == ROW_LAST) ? '0 : cur_row_p0 + ROW_W'(1);
    end
    top_p0  = line_buf[cur_col_p0];
    emit_p0 = in_valid && (cur_row_p0 != '0);
    last_p0 = in_valid && (cur_row_p0 == ROW_LAST) && (cur_col_p0 == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      prev_top    <= '0;
      prev_bottom <= '0;
    end else if (in_valid) begin
      col         <= nxt_col_p0;
      row         <= nxt_row_p0;
      prev_top    <= top_p0;
      prev_bottom <= cell_hist;
    end
  end

  // Contents survive reset; row 0 refills every entry before anything is read out.
  always_ff @(posedge clk) begin
    if (in_valid) line_buf[cur_col_p0] <= cell_hist;
  end

  // Stage p1: registered block output, held between valid cells
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      kb_p1  <= 1'b0;
      fd_p1  <= 1'b0;
      blk_p1 <= '0;
    end else begin
      vld_p1 <= emit_p0;
      fd_p1  <= last_p0;
      if (emit_p0) begin
        kb_p1  <= (cur_col_p0 == '0);
        blk_p1 <= {cell_hist, prev_bottom, top_p0, prev_top};
      end
    end
  end

  assign out_valid        = vld_p1;
  assign k_border         = kb_p1;
  assign frame_done       = fd_p1;
  assign block_histograms = blk_p1;

endmodule
